// File: rtl/instr_fetch_buffer_pkg.sv
// Shared widths and constants for the instruction fetch buffer.
package instr_fetch_buffer_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'hbfc0_0000;

    typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// Fetch / imem / decode signal bundle for the instruction fetch buffer.
interface instr_fetch_buffer_if;
    import instr_fetch_buffer_pkg::*;

    word_t pc;
    logic  flush;
    logic  imem_req;
    word_t imem_addr;
    logic  imem_gnt;
    logic  imem_rvalid;
    word_t imem_rdata;
    logic  stall;
    logic  instr_valid;
    word_t instr;
    word_t instr_pc;
    logic  dec_ready;

    modport slave (
        input  pc, flush, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        output imem_req, imem_addr, stall, instr_valid, instr, instr_pc
    );

    modport master (
        output pc, flush, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        input  imem_req, imem_addr, stall, instr_valid, instr, instr_pc
    );

endinterface

// File: rtl/ifb_slot_ram.sv
// DEPTH x 64 slot store: pc half written on issue, instr half written on
// response, asynchronous read of the head slot.
module ifb_slot_ram
    import instr_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     pc_we_i,
    input  logic [$clog2(DEPTH)-1:0] pc_waddr_i,
    input  word_t                    pc_wdata_i,
    input  logic                     instr_we_i,
    input  logic [$clog2(DEPTH)-1:0] instr_waddr_i,
    input  word_t                    instr_wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output word_t                    rd_pc_o,
    output word_t                    rd_instr_o
);

    logic [2*XLEN-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (pc_we_i) begin
            mem_q[pc_waddr_i][2*XLEN-1:XLEN] <= pc_wdata_i;
        end
        if (instr_we_i) begin
            mem_q[instr_waddr_i][XLEN-1:0] <= instr_wdata_i;
        end
    end

    assign rd_pc_o    = mem_q[raddr_i][2*XLEN-1:XLEN];
    assign rd_instr_o = mem_q[raddr_i][XLEN-1:0];

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues one imem request per accepted PC, queues the
// in-order responses with their PCs and presents them to decode (fall-through).
module instr_fetch_buffer
    import instr_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_buffer_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W:0] ptr_t;
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t ONE     = ptr_t'(1);

    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             fill_ptr_q, fill_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    ptr_t             inflight_q, inflight_d;
    ptr_t             stale_q, stale_d;
    logic [DEPTH-1:0] filled_q, filled_d;

    logic [PTR_W-1:0] wr_idx, fill_idx, rd_idx;
    logic             req, issue, rsp, live_rsp, head_valid, pop;
    word_t            head_pc, head_instr;

    assign wr_idx   = wr_ptr_q[PTR_W-1:0];
    assign fill_idx = fill_ptr_q[PTR_W-1:0];
    assign rd_idx   = rd_ptr_q[PTR_W-1:0];

    assign req   = ~reset & ~bus.flush
                 & ((wr_ptr_q - rd_ptr_q) != DEPTH_P)
                 & (inflight_q != DEPTH_P);
    assign issue = req & bus.imem_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp        = bus.imem_rvalid & (inflight_q != '0);
    assign live_rsp   = rsp & (stale_q == '0) & ~bus.flush;
    assign head_valid = (rd_ptr_q != fill_ptr_q) & filled_q[rd_idx];
    assign pop        = head_valid & bus.dec_ready & ~bus.flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        stale_d    = stale_q;
        filled_d   = filled_q;
        inflight_d = inflight_q + ptr_t'(issue) - ptr_t'(rsp);

        if (bus.flush) begin
            wr_ptr_d   = '0;
            fill_ptr_d = '0;
            rd_ptr_d   = '0;
            filled_d   = '0;
            // inflight already counts the stale responses, so after this
            // cycle every outstanding response is owed but unwanted.
            stale_d    = inflight_d;
        end else begin
            if (issue) begin
                wr_ptr_d = wr_ptr_q + ONE;
            end
            if (rsp) begin
                if (stale_q != '0) begin
                    stale_d = stale_q - ONE;
                end else begin
                    fill_ptr_d         = fill_ptr_q + ONE;
                    filled_d[fill_idx] = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d         = rd_ptr_q + ONE;
                filled_d[rd_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
            stale_q    <= '0;
            filled_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
            filled_q   <= filled_d;
        end
    end

    ifb_slot_ram #(
        .DEPTH (DEPTH)
    ) u_slot_ram (
        .clk_i         (clk),
        .pc_we_i       (issue),
        .pc_waddr_i    (wr_idx),
        .pc_wdata_i    (bus.pc),
        .instr_we_i    (live_rsp),
        .instr_waddr_i (fill_idx),
        .instr_wdata_i (bus.imem_rdata),
        .raddr_i       (rd_idx),
        .rd_pc_o       (head_pc),
        .rd_instr_o    (head_instr)
    );

    assign bus.imem_req    = req;
    assign bus.imem_addr   = bus.pc;
    assign bus.stall       = ~(reset | bus.flush | issue);
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_instr;
    assign bus.instr_pc    = head_pc;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Scoreboard bench for instr_fetch_buffer: fetch, imem and decode models drive
// the DUT; a monitor checks every decode handshake against granted PCs in order.
module tb_instr_fetch_buffer;
    import instr_fetch_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_buffer_if bus ();

    instr_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { word_t addr; word_t data; int due; } mreq_t;
    typedef struct { word_t pc; word_t instr; } exp_t;

    mreq_t mem_q[$];
    exp_t  exp_q[$];

    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    int    pops_seen = 0;
    word_t fetch_pc;
    word_t redirect_pc;
    int    gnt_mode, rdy_mode, lat_lo, lat_hi, data_mode;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Driver: fetch PC, imem grant/response, decode ready.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            bus.pc        = fetch_pc;
            bus.imem_gnt  = (gnt_mode == 1) || ((gnt_mode == 2) && ($urandom_range(0, 3) != 0));
            bus.dec_ready = (rdy_mode == 1) || ((rdy_mode == 2) && ($urandom_range(0, 1) == 1));
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_q[0].data;
                void'(mem_q.pop_front());
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = $urandom;
            end
        end
    end

    // Observer: records grants into the memory model and the scoreboard,
    // advances the fetch PC model.
    initial begin : observer
        logic  granted;
        logic  exp_stall;
        word_t d;
        forever begin
            @(negedge clk);
            if (reset) begin
                mem_q.delete();
                exp_q.delete();
                fetch_pc = RESET_VECTOR;
            end else begin
                granted   = bus.imem_req & bus.imem_gnt;
                exp_stall = ~(bus.flush | granted);
                check("stall", bus.stall, exp_stall);
                if (granted) begin
                    check("imem_addr", bus.imem_addr, fetch_pc);
                    d = (data_mode != 0) ? $urandom : (bus.imem_addr ^ 32'h1);
                    mem_q.push_back('{addr: bus.imem_addr, data: d,
                                      due: cyc + $urandom_range(lat_lo, lat_hi)});
                    exp_q.push_back('{pc: bus.imem_addr, instr: d});
                end
                check("outstanding_le_depth", (mem_q.size() <= DEPTH) ? 1 : 0, 1);
                if (bus.flush) begin
                    exp_q.delete();
                    fetch_pc = redirect_pc;
                end else if (!bus.stall) begin
                    fetch_pc = fetch_pc + 32'd4;
                end
            end
        end
    end

    // Monitor: every decode handshake must match the oldest live grant.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.instr_valid && bus.dec_ready && !bus.flush) begin
                pops_seen++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL decode_extra: got pc %h, expected no entry", bus.instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", bus.instr_pc, e.pc);
                    check("instr", bus.instr, e.instr);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_pop(input string name, input word_t want_pc, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (!reset && bus.instr_valid && bus.dec_ready && !bus.flush) begin
                got = 1'b1;
                check(name, bus.instr_pc, want_pc);
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no decode handshake within %0d cycles, expected pc %h",
                     name, budget, want_pc);
        end
    endtask

    initial begin
        int grants;
        reset           = 1'b1;
        bus.flush       = 1'b0;
        bus.pc          = RESET_VECTOR;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.dec_ready   = 1'b0;
        fetch_pc        = RESET_VECTOR;
        redirect_pc     = RESET_VECTOR;
        gnt_mode = 1; rdy_mode = 1; lat_lo = 1; lat_hi = 1; data_mode = 0;

        repeat (2) @(negedge clk);
        check("reset instr_valid", bus.instr_valid, 0);
        check("reset imem_req", bus.imem_req, 0);
        check("reset stall", bus.stall, 0);

        // 1: streaming, one-cycle latency, decode always ready
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t1 stall", bus.stall, 0);
            if (i == 0) check("t1 first addr", bus.imem_addr, RESET_VECTOR);
        end
        repeat (4) @(negedge clk);

        // 2: decode blocked, buffer fills, single pop frees one slot
        rdy_mode = 0;
        do_reset();
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_gnt) grants++;
        end
        check("t2 grants", grants, 4);
        check("t2 req full", bus.imem_req, 0);
        check("t2 stall full", bus.stall, 1);
        check("t2 head valid", bus.instr_valid, 1);
        @(posedge clk);
        rdy_mode = 1;
        @(negedge clk);
        check("t2 popped pc", bus.instr_pc, RESET_VECTOR);
        check("t2 req pop cycle", bus.imem_req, 0);
        @(posedge clk);
        rdy_mode = 0;
        @(negedge clk);
        check("t2 fifth req", bus.imem_req, 1);
        check("t2 fifth addr", bus.imem_addr, RESET_VECTOR + 32'h10);
        check("t2 fifth stall", bus.stall, 0);
        rdy_mode = 1;
        repeat (12) @(negedge clk);

        // 3: flush with two requests outstanding and no response that cycle
        lat_lo = 5; lat_hi = 5;
        do_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        redirect_pc = RESET_VECTOR + 32'h100;
        bus.flush   = 1'b1;
        @(negedge clk);
        check("t3 outstanding", mem_q.size(), 2);
        check("t3 no issue in flush", bus.imem_req, 0);
        check("t3 stall in flush", bus.stall, 0);
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("t3 valid after flush", bus.instr_valid, 0);
        wait_pop("t3 first after flush", RESET_VECTOR + 32'h100, 40);
        repeat (12) @(negedge clk);

        // 4: flush coincident with a response, three outstanding
        lat_lo = 3; lat_hi = 3;
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        redirect_pc = RESET_VECTOR + 32'h200;
        bus.flush   = 1'b1;
        @(negedge clk);
        check("t4 outstanding", mem_q.size(), 2);
        @(posedge clk);
        #1 bus.flush = 1'b0;
        wait_pop("t4 first after flush", RESET_VECTOR + 32'h200, 40);
        repeat (12) @(negedge clk);

        // 5: random grant, latency, ready and occasional redirects
        gnt_mode = 2; rdy_mode = 2; lat_lo = 1; lat_hi = 5; data_mode = 1;
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 99) == 0) begin
                redirect_pc = $urandom & 32'hffff_fffc;
                bus.flush   = 1'b1;
            end else begin
                bus.flush = 1'b0;
            end
        end
        @(posedge clk);
        gnt_mode = 0;
        rdy_mode = 1;
        #1 bus.flush = 1'b0;
        repeat (40) @(negedge clk);
        check("t5 drained", exp_q.size(), 0);
        check("t5 activity", (pops_seen > 100) ? 1 : 0, 1);

        // 6: asynchronous reset with three entries buffered
        gnt_mode = 1; rdy_mode = 0; lat_lo = 1; lat_hi = 1; data_mode = 0;
        do_reset();
        repeat (3) @(negedge clk);
        gnt_mode = 0;
        repeat (3) @(negedge clk);
        check("t6 buffered valid", bus.instr_valid, 1);
        check("t6 buffered head", bus.instr_pc, RESET_VECTOR);
        check("t6 req before reset", bus.imem_req, 1);
        #2 reset = 1'b1;
        #1;
        check("t6 async instr_valid", bus.instr_valid, 0);
        check("t6 async imem_req", bus.imem_req, 0);
        check("t6 async stall", bus.stall, 0);
        gnt_mode = 1;
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_pop("t6 restart", RESET_VECTOR, 20);
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
